// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle controller: state codes, ALU codes, cmd codes, mux selects.
package ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_EXECMUL  = 4'd8;
    localparam logic [3:0] S_ALUWB    = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_UNKNOWN  = 4'd11;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] SRCA_REG   = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALUControl / FlagW decode from Funct, active only in the execute states.
// Multiply code 100 exists only when MC_CONTROLLER_MUL_EN is defined.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic       exec_i,
    input  logic       mul_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic [1:0] flag_w_o
);

    logic [3:0] cmd;
    logic       s_bit;
    assign cmd   = funct_i[4:1];
    assign s_bit = funct_i[0];

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        flag_w_o   = 2'b00;
        if (exec_i) begin
            case (cmd)
                CMD_ADD: alu_ctrl_o = ALU_ADD;
                CMD_SUB: alu_ctrl_o = ALU_SUB;
                CMD_AND: alu_ctrl_o = ALU_AND;
                CMD_ORR: alu_ctrl_o = ALU_ORR;
                CMD_MOV: alu_ctrl_o = ALU_MOV;
                default: alu_ctrl_o = ALU_ADD;
            endcase
            flag_w_o[1] = s_bit;
            flag_w_o[0] = s_bit && (cmd == CMD_ADD || cmd == CMD_SUB);
`ifdef MC_CONTROLLER_MUL_EN
            if (mul_i) begin
                alu_ctrl_o  = ALU_MUL;
                flag_w_o[0] = 1'b0;
            end
`endif
        end
    end

`ifndef MC_CONTROLLER_MUL_EN
    logic unused_mul;
    assign unused_mul = mul_i;
`endif

endmodule

// File: rtl/mc_controller.sv
// Moore FSM for the multicycle datapath; strobes/selects decode from state only.
// Optional multiply path enabled by MC_CONTROLLER_MUL_EN.
module mc_controller
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       Mul,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       Illegal
);

    logic [3:0] state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
                    OP_DP: begin
                        if (Funct[5]) state_d = S_EXECUTEI;
`ifdef MC_CONTROLLER_MUL_EN
                        else if (Mul) state_d = S_EXECMUL;
`endif
                        else          state_d = S_EXECUTER;
                    end
                    default: state_d = S_UNKNOWN;
                endcase
            end
            S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER, S_EXECUTEI, S_EXECMUL: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

`ifndef MC_CONTROLLER_MUL_EN
    logic unused_mul_in;
    assign unused_mul_in = Mul;
`endif

    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        Illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
            end
            S_MEMADR:   ALUSrcB = SRCB_IMM;
            S_MEMREAD:  AdrSrc  = 1'b1;
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            S_MEMWB: begin
                RegW      = 1'b1;
                ResultSrc = RES_DATA;
            end
            S_EXECUTEI: ALUSrcB = SRCB_IMM;
            S_ALUWB:    RegW    = 1'b1;
            S_BRANCH: begin
                Branch    = 1'b1;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
            end
            S_UNKNOWN:  Illegal = 1'b1;
            default: ;
        endcase
    end

    logic exec_st;
    assign exec_st = (state_q == S_EXECUTER) || (state_q == S_EXECUTEI) || (state_q == S_EXECMUL);

    alu_decoder u_alu_dec (
        .exec_i     (exec_st),
        .mul_i      (state_q == S_EXECMUL),
        .funct_i    (Funct),
        .alu_ctrl_o (ALUControl),
        .flag_w_o   (FlagW)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Directed table-driven bench for mc_controller; expectations follow MC_CONTROLLER_MUL_EN if defined.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       Mul;
    logic       IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, Illegal;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, FlagW;
    logic [2:0] ALUControl;

    mc_controller dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Mul(Mul),
        .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .Branch(Branch),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ALUControl(ALUControl), .FlagW(FlagW), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    // {IRWrite,NextPC,RegW,MemW,Branch,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,FlagW,Illegal}
    logic [17:0] obs;
    assign obs = {IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUSrcA, ALUSrcB,
                  ResultSrc, ALUControl, FlagW, Illegal};

    localparam logic [17:0] E_FETCH = {6'b110000, 2'b01, 2'b10, 2'b10, 3'b000, 2'b00, 1'b0};
    localparam logic [17:0] E_DEC   = {6'b000000, 2'b01, 2'b10, 2'b10, 3'b000, 2'b00, 1'b0};
    localparam logic [17:0] E_MADR  = {6'b000000, 2'b00, 2'b01, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [17:0] E_MRD   = {6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [17:0] E_MWR   = {6'b000101, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [17:0] E_MWB   = {6'b001000, 2'b00, 2'b00, 2'b01, 3'b000, 2'b00, 1'b0};
    localparam logic [17:0] E_EXR   = {6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [17:0] E_EXI   = {6'b000000, 2'b00, 2'b01, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [17:0] E_AWB   = {6'b001000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0};
    localparam logic [17:0] E_BR    = {6'b000010, 2'b00, 2'b01, 2'b10, 3'b000, 2'b00, 1'b0};
    localparam logic [17:0] E_UNK   = {6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1};

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic        mul;
        int          len;
        logic [4:0][17:0] exp;
    } vec_t;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    function automatic logic [17:0] ex(logic [17:0] base, logic [2:0] alu, logic [1:0] fw);
        return base | {12'b0, alu, fw, 1'b0};
    endfunction

    function automatic vec_t mk(string nm, logic [1:0] op, logic [5:0] f, logic m, int len,
                                logic [17:0] e2, logic [17:0] e3, logic [17:0] e4);
        vec_t v;
        v.name = nm; v.op = op; v.funct = f; v.mul = m; v.len = len;
        v.exp[0] = E_FETCH; v.exp[1] = E_DEC; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
        return v;
    endfunction

    task automatic check(string nm, logic [17:0] act, logic [17:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, req);
        end
    endtask

    // Inputs are only valid in DECODE (and Funct from DECODE onward); other cycles carry junk.
    task automatic run_vec(vec_t v);
        for (int k = 0; k < v.len; k++) begin
            @(negedge clk);
            Op    = (k == 1) ? v.op  : ~v.op;
            Mul   = (k == 1) ? v.mul : ~v.mul;
            Funct = (k == 0) ? 6'($urandom) : v.funct;
            #1;
            check($sformatf("%s[c%0d]", v.name, k), obs, v.exp[k]);
        end
    endtask

    initial begin
        vecs.push_back(mk("ldr",      2'b01, 6'b000001, 1'b0, 5, E_MADR, E_MRD, E_MWB));
        vecs.push_back(mk("str",      2'b01, 6'b000000, 1'b0, 4, E_MADR, E_MWR, E_FETCH));
        vecs.push_back(mk("subi_s",   2'b00, 6'b100101, 1'b0, 4, ex(E_EXI, 3'b001, 2'b11), E_AWB, E_FETCH));
        vecs.push_back(mk("addi_s",   2'b00, 6'b101001, 1'b0, 4, ex(E_EXI, 3'b000, 2'b11), E_AWB, E_FETCH));
        vecs.push_back(mk("orr_s",    2'b00, 6'b011001, 1'b0, 4, ex(E_EXR, 3'b011, 2'b10), E_AWB, E_FETCH));
        vecs.push_back(mk("mov",      2'b00, 6'b011010, 1'b0, 4, ex(E_EXR, 3'b101, 2'b00), E_AWB, E_FETCH));
        vecs.push_back(mk("add",      2'b00, 6'b001000, 1'b0, 4, ex(E_EXR, 3'b000, 2'b00), E_AWB, E_FETCH));
        vecs.push_back(mk("and_s",    2'b00, 6'b000001, 1'b0, 4, ex(E_EXR, 3'b010, 2'b10), E_AWB, E_FETCH));
        vecs.push_back(mk("other_s",  2'b00, 6'b010101, 1'b0, 4, ex(E_EXR, 3'b000, 2'b10), E_AWB, E_FETCH));
`ifdef MC_CONTROLLER_MUL_EN
        vecs.push_back(mk("mul_s",    2'b00, 6'b001001, 1'b1, 4, ex(E_EXR, 3'b100, 2'b10), E_AWB, E_FETCH));
`else
        vecs.push_back(mk("mul_s",    2'b00, 6'b001001, 1'b1, 4, ex(E_EXR, 3'b000, 2'b11), E_AWB, E_FETCH));
`endif
        vecs.push_back(mk("mul_imm",  2'b00, 6'b101000, 1'b1, 4, ex(E_EXI, 3'b000, 2'b00), E_AWB, E_FETCH));
        vecs.push_back(mk("branch",   2'b10, 6'b000000, 1'b0, 3, E_BR, E_FETCH, E_FETCH));
        vecs.push_back(mk("illegal",  2'b11, 6'b111111, 1'b0, 3, E_UNK, E_FETCH, E_FETCH));

        Op = 2'b00; Funct = 6'b0; Mul = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_async", obs, E_FETCH);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", obs, E_FETCH);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_release", obs, E_FETCH);
        @(posedge clk);
        #1;
        check("first_edge_decode", obs, E_DEC);
        Op = 2'b10;
        @(posedge clk);
        @(posedge clk);
        // Back in FETCH after the branch; the table run starts here.

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset mid-MEMWRITE: run a store up to MEMWRITE, then pulse reset between edges.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            Op = 2'b01; Funct = 6'b000000; Mul = 1'b0;
            #1;
            if (k == 3) check("pre_abort_memw", obs, E_MWR);
        end
        #2;
        reset = 1'b1;
        #1;
        check("abort_to_fetch", obs, E_FETCH);
        @(posedge clk);
        #1;
        check("abort_hold_no_memw", obs, E_FETCH);
        @(negedge clk);
        reset = 1'b0;
        Op = 2'b11;
        @(posedge clk);
        #1;
        check("post_abort_decode", obs, E_DEC);
        @(posedge clk);
        #1;
        check("illegal_cycle", obs, E_UNK);
        @(posedge clk);
        #1;
        check("illegal_one_cycle", obs, E_FETCH);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
